// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode codes and flag bit indices shared by the flag register and branch sequencer
package cpu_pkg;
  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_CMP  = 5'h05;
  localparam logic [4:0] OP_LDIF = 5'h19;
  localparam logic [4:0] OP_MOVF = 5'h1A;
  localparam logic [4:0] OP_BR   = 5'h1B;
  localparam logic [4:0] OP_JMP  = 5'h1C;
  localparam logic [4:0] OP_CALL = 5'h1D;
  localparam logic [4:0] OP_RET  = 5'h1E;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address buffer that overwrites its oldest entry on a full push
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int AW = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int DW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  always_comb begin
    top = mem[ptr - PW'(1)];
    full = depth == DW'(DEPTH);
    empty = depth == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      depth <= '0;
    end else if (push) begin
      mem[ptr] <= din;
      ptr <= ptr + PW'(1);
      depth <= full ? depth : depth + DW'(1);
    end else if (pop) begin
      ptr <= ptr - PW'(1);
      depth <= depth - DW'(1);
    end
  end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: resolves BR/JMP/CALL/RET against registered flags and owns the fetch pc
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  input  logic [4:0]                   opcode,
  input  logic [2:0]                   cond_sel,
  input  logic                         cond_pol,
  input  logic [AW-1:0]                target,
  input  logic [7:0]                   flags,
  input  logic                         stall,
  output logic [AW-1:0]                pc,
  output logic                         flush,
  output logic [$clog2(RAS_DEPTH):0]   ras_depth,
  output logic                         ras_ovf,
  output logic                         ras_unf
);
  logic active, taken, jmp, call, ret_hit, ret_miss, redirect, full, empty;
  logic [AW-1:0] top, pc_next;
  always_comb begin
    active = !stall && !flush && instr_valid;
    taken = active && opcode == OP_BR && flags[cond_sel] == cond_pol;
    jmp = active && opcode == OP_JMP;
    call = active && opcode == OP_CALL;
    ret_hit = active && opcode == OP_RET && !empty;
    ret_miss = active && opcode == OP_RET && empty;
    redirect = taken || jmp || call || ret_hit;
    pc_next = ret_hit ? top : redirect ? target : pc + AW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      flush <= 1'b0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (!stall) begin
      pc <= pc_next;
      flush <= redirect;
      ras_ovf <= ras_ovf | (call && full);
      ras_unf <= ras_unf | ret_miss;
    end
  end
  return_addr_stack #(.DEPTH(RAS_DEPTH), .AW(AW)) u_ras (
    .clk(clk),
    .rst(reset),
    .push(call),
    .pop(ret_hit),
    .din(pc),
    .top(top),
    .depth(ras_depth),
    .full(full),
    .empty(empty)
  );
endmodule
